// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and a DMA engine
// Ports: cpu_* / dma_* requester interfaces (req, we, byte_op, addr, wd, gnt, rvalid, rd, dma_last_i),
//        mem_* memory port (we, byte_op, addr, wd out; rd in, combinational), addr_err_o range-error pulse.
// Optional: define DMEM_ARB_STATS_EN to add stat_cpu_gnt_o, stat_dma_gnt_o, stat_conflict_o counters.
module dmem_arbiter #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 'h10000,
    parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 'h1FFFF,
    parameter int                    MAX_WAIT      = 4,
    parameter int                    BURST_MAX     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_byte_op_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wd_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rd_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic                  dma_byte_op_i,
    input  logic [DATA_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wd_i,
    input  logic                  dma_last_i,
    output logic                  dma_gnt_o,
    output logic                  dma_rvalid_o,
    output logic [DATA_WIDTH-1:0] dma_rd_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic                  addr_err_o
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_cpu_gnt_o,
    output logic [31:0]           stat_dma_gnt_o,
    output logic [31:0]           stat_conflict_o
`endif
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
    localparam logic [BW-1:0] B_MAX = BW'(BURST_MAX);

    typedef enum logic {IDLE, DMA_BURST} state_t;

    state_t                state;
    logic [WW-1:0]         wait_cnt;
    logic [BW-1:0]         beat_cnt;
    logic                  burst_block;
    logic                  dma_force;
    logic                  g_we;
    logic                  g_byte;
    logic [DATA_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH:0]   addr_top;
    logic                  legal;

    // a starved DMA overrides the CPU only while it is still requesting
    assign dma_force = dma_req_i && wait_cnt == W_MAX;
    assign cpu_gnt_o = state == IDLE && cpu_req_i && !dma_force;
    assign dma_gnt_o = dma_req_i && (state == DMA_BURST || !cpu_req_i || dma_force);

    assign g_we   = cpu_gnt_o ? cpu_we_i      : dma_gnt_o ? dma_we_i      : 1'b0;
    assign g_byte = cpu_gnt_o ? cpu_byte_op_i : dma_gnt_o ? dma_byte_op_i : 1'b0;
    assign g_addr = cpu_gnt_o ? cpu_addr_i    : dma_gnt_o ? dma_addr_i    : '0;

    // last byte touched, one bit wider so addresses near the top cannot wrap
    assign addr_top = {1'b0, g_addr} + (g_byte ? '0 : (DATA_WIDTH + 1)'(3));
    assign legal    = g_addr >= START_ADDRESS && addr_top <= {1'b0, END_ADDRESS};

    assign mem_we_o      = g_we && legal;
    assign mem_byte_op_o = g_byte;
    assign mem_addr_o    = g_addr;
    assign mem_wd_o      = cpu_gnt_o ? cpu_wd_i : dma_gnt_o ? dma_wd_i : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            beat_cnt     <= '0;
            burst_block  <= 1'b0;
            cpu_rvalid_o <= 1'b0;
            dma_rvalid_o <= 1'b0;
            cpu_rd_o     <= '0;
            dma_rd_o     <= '0;
            addr_err_o   <= 1'b0;
        end else begin
            cpu_rvalid_o <= cpu_gnt_o && !cpu_we_i;
            dma_rvalid_o <= dma_gnt_o && !dma_we_i;
            if (cpu_gnt_o && !cpu_we_i)
                cpu_rd_o <= legal ? mem_rd_i : '0;
            if (dma_gnt_o && !dma_we_i)
                dma_rd_o <= legal ? mem_rd_i : '0;
            addr_err_o <= (cpu_gnt_o || dma_gnt_o) && !legal;
            wait_cnt   <= (!dma_req_i || dma_gnt_o) ? '0 : wait_cnt == W_MAX ? W_MAX : wait_cnt + 1'b1;
            if (state == IDLE) begin
                // the block left by a full-length burst lifts once the CPU is served or idle
                if (cpu_gnt_o || !cpu_req_i)
                    burst_block <= 1'b0;
                if (dma_gnt_o && !dma_last_i && !burst_block) begin
                    state    <= DMA_BURST;
                    beat_cnt <= BW'(1);
                end
            end else if (!dma_req_i || dma_last_i || beat_cnt + 1'b1 == B_MAX) begin
                state       <= IDLE;
                beat_cnt    <= '0;
                burst_block <= dma_req_i && !dma_last_i;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cpu_gnt_o  <= '0;
            stat_dma_gnt_o  <= '0;
            stat_conflict_o <= '0;
        end else begin
            stat_cpu_gnt_o  <= stat_cpu_gnt_o + 32'(cpu_gnt_o);
            stat_dma_gnt_o  <= stat_dma_gnt_o + 32'(dma_gnt_o);
            stat_conflict_o <= stat_conflict_o + 32'(cpu_req_i && dma_req_i);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam logic [31:0] START = 32'h10000;
    localparam logic [31:0] ENDA  = 32'h1FFFF;
    localparam int MAXW = 4;
    localparam int BMAX = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_req, cpu_we, cpu_byte, dma_req, dma_we, dma_byte, dma_last;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, mem_rd;
    logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, mem_byte, addr_err;
    logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu, stat_dma, stat_conf;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_byte_op_i(cpu_byte),
        .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rd_o(cpu_rd),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_byte_op_i(dma_byte),
        .dma_addr_i(dma_addr), .dma_wd_i(dma_wd), .dma_last_i(dma_last),
        .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rd_o(dma_rd),
        .mem_we_o(mem_we), .mem_byte_op_o(mem_byte), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .addr_err_o(addr_err)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_gnt_o(stat_cpu), .stat_dma_gnt_o(stat_dma), .stat_conflict_o(stat_conf)
`endif
    );

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wd = 0;
        dma_req = 0; dma_we = 0; dma_byte = 0; dma_addr = 0; dma_wd = 0; dma_last = 0;
        mem_rd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10000; mem_rd = 32'h1234;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        total += 5;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL reset cpu_rvalid got=%b exp=0", cpu_rvalid); end
        if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset dma_rvalid got=%b exp=0", dma_rvalid); end
        if (cpu_rd !== 32'h0) begin bad++; $display("FAIL reset cpu_rd got=%h exp=0", cpu_rd); end
        if (dma_rd !== 32'h0) begin bad++; $display("FAIL reset dma_rd got=%h exp=0", dma_rd); end
        if (addr_err !== 1'b0) begin bad++; $display("FAIL reset addr_err got=%b exp=0", addr_err); end
        @(negedge clk);
        total += 3;
        if ({cpu_gnt, dma_gnt} !== 2'b00) begin bad++; $display("FAIL reset grants got=%b exp=00", {cpu_gnt, dma_gnt}); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we got=%b exp=0", mem_we); end
        if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10004; mem_rd = 32'hDEADBEEF;
        dma_addr = 32'h10100;
        @(negedge clk);
        total += 4;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL cpu_read gnt got=%b exp=1", cpu_gnt); end
        if (dma_gnt !== 1'b0) begin bad++; $display("FAIL cpu_read dma_gnt got=%b exp=0", dma_gnt); end
        if (mem_addr !== 32'h10004) begin bad++; $display("FAIL cpu_read mem_addr got=%h exp=10004", mem_addr); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL cpu_read mem_we got=%b exp=0", mem_we); end
        @(posedge clk); #1;
        cpu_req = 0; mem_rd = 32'h0;
        total += 3;
        if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL cpu_read rvalid got=%b exp=1", cpu_rvalid); end
        if (cpu_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_read rd got=%h exp=deadbeef", cpu_rd); end
        if (addr_err !== 1'b0) begin bad++; $display("FAIL cpu_read addr_err got=%b exp=0", addr_err); end
        @(posedge clk); #1;
        total += 2;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_read rvalid_drop got=%b exp=0", cpu_rvalid); end
        if (cpu_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_read rd_hold got=%h exp=deadbeef", cpu_rd); end
    endtask

    task automatic test_starvation();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10010;
        dma_req = 1; dma_addr = 32'h10020; dma_last = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({cpu_gnt, dma_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL starvation cycle %0d cpu/dma gnt got=%b exp=%b", c, {cpu_gnt, dma_gnt}, (c == 4) ? 2'b01 : 2'b10);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_burst_last();
        do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 32'h10040; dma_wd = 32'hA5A5_0001;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) cpu_req = 1;
            dma_last = (c == 2);
            if (c == 3) dma_req = 0;
            dma_wd = 32'hA5A5_0001 + c;
            @(negedge clk);
            total += 2;
            if ({cpu_gnt, dma_gnt} !== ((c < 3) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL burst_last cycle %0d cpu/dma gnt got=%b exp=%b", c, {cpu_gnt, dma_gnt}, (c < 3) ? 2'b01 : 2'b10);
            end
            if (c < 3 && (mem_we !== 1'b1 || mem_wd !== 32'hA5A5_0001 + c)) begin
                bad++; $display("FAIL burst_last cycle %0d we/wd got=%b/%h exp=1/%h", c, mem_we, mem_wd, 32'hA5A5_0001 + c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_burst_max();
        logic [1:0] e;
        do_reset();
        dma_req = 1; dma_addr = 32'h10080;
        for (int c = 0; c < 11; c++) begin
            cpu_req = (c >= 1 && c != 9);
            dma_last = (c == 10);
            e = (c == 8) ? 2'b10 : 2'b01;
            @(negedge clk);
            total++;
            if ({cpu_gnt, dma_gnt} !== e) begin bad++; $display("FAIL burst_max cycle %0d cpu/dma gnt got=%b exp=%b", c, {cpu_gnt, dma_gnt}, e); end
            @(posedge clk); #1;
        end
        do_reset();
        dma_req = 1; dma_addr = 32'h10080;
        for (int c = 0; c < 10; c++) begin
            cpu_req = (c >= 1 && c != 8);
            e = (c == 9) ? 2'b10 : 2'b01;
            @(negedge clk);
            total++;
            if ({cpu_gnt, dma_gnt} !== e) begin bad++; $display("FAIL burst_block cycle %0d cpu/dma gnt got=%b exp=%b", c, {cpu_gnt, dma_gnt}, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [5] = '{32'h0000FFFF, 32'h0001FFFD, 32'h0001FFFC, 32'h0001FFFF, 32'h0000FFFC};
        logic        bytes [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        wes   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        oks   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cpu_req = 1; cpu_we = wes[i]; cpu_byte = bytes[i]; cpu_addr = addrs[i];
            cpu_wd = 32'h5555_0000 + i; mem_rd = 32'hFFFF_FFFF;
            @(negedge clk);
            total += 2;
            if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL range %0d gnt got=%b exp=1", i, cpu_gnt); end
            if (mem_we !== (wes[i] && oks[i])) begin bad++; $display("FAIL range %0d mem_we got=%b exp=%b", i, mem_we, wes[i] && oks[i]); end
            @(posedge clk); #1;
            cpu_req = 0;
            total += 2;
            if (addr_err !== !oks[i]) begin bad++; $display("FAIL range %0d addr_err got=%b exp=%b", i, addr_err, !oks[i]); end
            if (cpu_rvalid !== !wes[i]) begin bad++; $display("FAIL range %0d rvalid got=%b exp=%b", i, cpu_rvalid, !wes[i]); end
            if (!wes[i]) begin
                total++;
                if (cpu_rd !== 32'h0) begin bad++; $display("FAIL range %0d rd got=%h exp=0", i, cpu_rd); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        dma_req = 1; dma_addr = 32'h10200; mem_rd = 32'h7777;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        cpu_req = 1; cpu_addr = 32'h10300;
        total += 2;
        if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL mid_reset dma_rvalid got=%b exp=0", dma_rvalid); end
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL mid_reset cpu_rvalid got=%b exp=0", cpu_rvalid); end
        @(negedge clk);
        total++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin bad++; $display("FAIL mid_reset cpu/dma gnt got=%b exp=10", {cpu_gnt, dma_gnt}); end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return START + $urandom_range(0, 32'hFFFF);
            1: return ENDA - $urandom_range(0, 5);
            2: return START - $urandom_range(1, 3);
            3: return $urandom;
            default: return START + $urandom_range(0, 15);
        endcase
    endfunction

    // reference: grants from ownership, starvation count and burst length rules
    task automatic test_random();
        bit in_burst = 0, blocked = 0;
        int waited = 0, beats = 0;
        bit e_cpu, e_dma, ok, e_we, e_byte;
        logic [31:0] e_addr, e_wd;
        bit n_crv, n_drv, n_err;
        logic [31:0] n_crd = 0, n_drd = 0;
        longint unsigned last_byte;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cpu_req = ($urandom_range(0, 9) < 6); cpu_we = $urandom_range(0, 1); cpu_byte = $urandom_range(0, 1);
            cpu_addr = rand_addr(); cpu_wd = $urandom;
            dma_req = ($urandom_range(0, 9) < 7); dma_we = $urandom_range(0, 1); dma_byte = $urandom_range(0, 1);
            dma_addr = rand_addr(); dma_wd = $urandom; dma_last = ($urandom_range(0, 9) == 0);
            mem_rd = $urandom;
            e_dma = dma_req && (in_burst || !cpu_req || waited >= MAXW);
            e_cpu = cpu_req && !in_burst && !e_dma;
            e_addr = e_cpu ? cpu_addr : e_dma ? dma_addr : 32'h0;
            e_byte = e_cpu ? cpu_byte : e_dma ? dma_byte : 1'b0;
            e_wd = e_cpu ? cpu_wd : e_dma ? dma_wd : 32'h0;
            last_byte = longint'(e_addr) + (e_byte ? 0 : 3);
            ok = e_addr >= START && last_byte <= longint'(ENDA);
            e_we = ((e_cpu && cpu_we) || (e_dma && dma_we)) && ok;
            @(negedge clk);
            total += 6;
            if (cpu_gnt !== e_cpu) begin bad++; $display("FAIL rand %0d cpu_gnt got=%b exp=%b", c, cpu_gnt, e_cpu); end
            if (dma_gnt !== e_dma) begin bad++; $display("FAIL rand %0d dma_gnt got=%b exp=%b", c, dma_gnt, e_dma); end
            if (mem_we !== e_we) begin bad++; $display("FAIL rand %0d mem_we got=%b exp=%b", c, mem_we, e_we); end
            if (mem_addr !== e_addr) begin bad++; $display("FAIL rand %0d mem_addr got=%h exp=%h", c, mem_addr, e_addr); end
            if (mem_byte !== e_byte) begin bad++; $display("FAIL rand %0d mem_byte got=%b exp=%b", c, mem_byte, e_byte); end
            if (mem_wd !== e_wd) begin bad++; $display("FAIL rand %0d mem_wd got=%h exp=%h", c, mem_wd, e_wd); end
            n_crv = e_cpu && !cpu_we;
            n_drv = e_dma && !dma_we;
            if (n_crv) n_crd = ok ? mem_rd : 32'h0;
            if (n_drv) n_drd = ok ? mem_rd : 32'h0;
            n_err = (e_cpu || e_dma) && !ok;
            if (in_burst) begin
                if (!dma_req) begin
                    in_burst = 0; beats = 0;
                end else begin
                    beats++;
                    if (dma_last || beats == BMAX) begin
                        in_burst = 0; blocked = !dma_last; beats = 0;
                    end
                end
            end else begin
                if (e_dma && !dma_last && !blocked) begin in_burst = 1; beats = 1; end
                if (e_cpu || !cpu_req) blocked = 0;
            end
            waited = (!dma_req || e_dma) ? 0 : (waited < MAXW ? waited + 1 : MAXW);
            @(posedge clk); #1;
            total += 5;
            if (cpu_rvalid !== n_crv) begin bad++; $display("FAIL rand %0d cpu_rvalid got=%b exp=%b", c, cpu_rvalid, n_crv); end
            if (dma_rvalid !== n_drv) begin bad++; $display("FAIL rand %0d dma_rvalid got=%b exp=%b", c, dma_rvalid, n_drv); end
            if (cpu_rd !== n_crd) begin bad++; $display("FAIL rand %0d cpu_rd got=%h exp=%h", c, cpu_rd, n_crd); end
            if (dma_rd !== n_drd) begin bad++; $display("FAIL rand %0d dma_rd got=%h exp=%h", c, dma_rd, n_drd); end
            if (addr_err !== n_err) begin bad++; $display("FAIL rand %0d addr_err got=%b exp=%b", c, addr_err, n_err); end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_cpu_read();
        test_starvation();
        test_burst_last();
        test_burst_max();
        test_range();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
